// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state codes,
// instruction classes, opcode constants, datapath select codes and the
// opcode-to-class decoder used in ID.
package mc_control_fsm_pkg;

  localparam logic [2:0] ST_IF    = 3'd0;
  localparam logic [2:0] ST_ID    = 3'd1;
  localparam logic [2:0] ST_EX    = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
  localparam logic [2:0] ST_FAULT = 3'd6;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ECALL, CLS_ILLEGAL
  } instr_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] ASRC_PC   = 2'd0;
  localparam logic [1:0] ASRC_RS1  = 2'd1;
  localparam logic [1:0] ASRC_ZERO = 2'd2;

  localparam logic [1:0] BSRC_REG  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  function automatic instr_class_e decode_class(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_LUI:    return CLS_LUI;
      OP_AUIPC:  return CLS_AUIPC;
      OP_SYSTEM: return CLS_ECALL;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Memory wait-state counter.
//   clk, rst : clock, async active-high reset
//   clr      : clear the count (request completed or state changed)
//   inc      : one more cycle with a request pending and no ready
//   timeout  : count has reached MEM_TIMEOUT
module mem_wait_timer #(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (inc) cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == TIMEOUT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM (IF, ID, EX, MEM, WB, HALT, FAULT).
//   Inputs : clk, reset (async, active high), opcode, bcond, halt_req,
//            mem_ready
//   Outputs: memory handshake/strobes, IR/regfile/PC enables, datapath
//            selects, sticky is_halted/fault, retired_count
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             is_halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired_count
);

  logic [2:0]       state_q, state_d;
  instr_class_e     class_q, class_d, cls_id;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire, timeout;

  logic       req_c, iord_c, rd_c, wr_c, irw_c, rw_c, pcw_c;
  logic [1:0] wb_c, a_c, b_c, op_c, pcs_c;

  always_comb begin
    cls_id  = decode_class(opcode);
    state_d = state_q;
    class_d = class_q;
    retire  = 1'b0;
    req_c = 1'b0; iord_c = 1'b0; rd_c = 1'b0; wr_c = 1'b0;
    irw_c = 1'b0; rw_c = 1'b0; pcw_c = 1'b0;
    wb_c = WB_ALUOUT; a_c = ASRC_PC; b_c = BSRC_REG;
    op_c = ALUOP_ADD; pcs_c = PCSRC_PC4;

    case (state_q)
      ST_IF: begin
        req_c = 1'b1;
        rd_c  = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          state_d = ST_ID;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_ID: begin
        // ALUOut <= PC + imm: branch/JAL target ready for EX
        a_c = ASRC_PC; b_c = BSRC_IMM; op_c = ALUOP_ADD;
        class_d = cls_id;
        case (cls_id)
          CLS_ILLEGAL: state_d = ST_FAULT;
          CLS_ECALL: begin
            if (halt_req) state_d = ST_HALT;
            else begin
              pcw_c = 1'b1; pcs_c = PCSRC_PC4; retire = 1'b1;
              state_d = ST_IF;
            end
          end
          default: state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        case (class_q)
          CLS_R:     begin a_c = ASRC_RS1;  b_c = BSRC_REG; op_c = ALUOP_FUNCT; state_d = ST_WB; end
          CLS_I:     begin a_c = ASRC_RS1;  b_c = BSRC_IMM; op_c = ALUOP_FUNCT; state_d = ST_WB; end
          CLS_LUI:   begin a_c = ASRC_ZERO; b_c = BSRC_IMM; state_d = ST_WB; end
          CLS_AUIPC: begin a_c = ASRC_PC;   b_c = BSRC_IMM; state_d = ST_WB; end
          CLS_LOAD, CLS_STORE: begin
            a_c = ASRC_RS1; b_c = BSRC_IMM; state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            a_c = ASRC_RS1; b_c = BSRC_REG; op_c = ALUOP_BRANCH;
            pcw_c = 1'b1; pcs_c = bcond ? PCSRC_ALUOUT : PCSRC_PC4;
            retire = 1'b1; state_d = ST_IF;
          end
          CLS_JAL: begin
            rw_c = 1'b1; wb_c = WB_PC4; pcw_c = 1'b1; pcs_c = PCSRC_ALUOUT;
            retire = 1'b1; state_d = ST_IF;
          end
          CLS_JALR: begin
            a_c = ASRC_RS1; b_c = BSRC_IMM;
            rw_c = 1'b1; wb_c = WB_PC4; pcw_c = 1'b1; pcs_c = PCSRC_JALR;
            retire = 1'b1; state_d = ST_IF;
          end
          default: state_d = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        rd_c   = (class_q == CLS_LOAD);
        wr_c   = (class_q != CLS_LOAD);
        if (mem_ready) begin
          if (class_q == CLS_LOAD) state_d = ST_WB;
          else begin
            pcw_c = 1'b1; pcs_c = PCSRC_PC4; retire = 1'b1;
            state_d = ST_IF;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rw_c  = 1'b1;
        wb_c  = (class_q == CLS_LOAD) ? WB_MDR : WB_ALUOUT;
        pcw_c = 1'b1; pcs_c = PCSRC_PC4;
        retire = 1'b1; state_d = ST_IF;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Any state change (including completion) restarts the wait count.
  mem_wait_timer #(
    .TIMEOUT_W   (TIMEOUT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .clr     (state_d != state_q),
    .inc     (req_c & ~mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IF;
      class_q   <= CLS_ILLEGAL;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      retired_q <= retired_d;
    end
  end

  // Reset forces every output low at once, even though the state register
  // sits in IF, so no request is issued while reset is held.
  assign mem_req       = req_c  & ~reset;
  assign i_or_d        = iord_c & ~reset;
  assign mem_read      = rd_c   & ~reset;
  assign mem_write     = wr_c   & ~reset;
  assign ir_write      = irw_c  & ~reset;
  assign reg_write     = rw_c   & ~reset;
  assign pc_write      = pcw_c  & ~reset;
  assign wb_sel        = reset ? 2'd0 : wb_c;
  assign alu_src_a     = reset ? 2'd0 : a_c;
  assign alu_src_b     = reset ? 2'd0 : b_c;
  assign alu_op_sel    = reset ? 2'd0 : op_c;
  assign pc_source     = reset ? 2'd0 : pcs_c;
  assign is_halted     = (state_q == ST_HALT)  & ~reset;
  assign fault         = (state_q == ST_FAULT) & ~reset;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int TO = 15;

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                         O_SYS = 7'b1110011;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5,
                 K_ECALL = 6, K_ILL = 7;

  logic        clk = 1'b0, reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        bcond = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic        mem_req, i_or_d, mem_read, mem_write, ir_write, reg_write, pc_write;
  logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op_sel, pc_source;
  logic        is_halted, fault;
  logic [31:0] retired_count;
  logic [18:0] outs;

  int n_tests = 0, n_fail = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT_W(4), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .pc_write(pc_write), .pc_source(pc_source), .is_halted(is_halted), .fault(fault),
    .retired_count(retired_count)
  );

  assign outs = {mem_req, i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel,
                 alu_src_a, alu_src_b, alu_op_sel, pc_write, pc_source, is_halted, fault};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int kind(input logic [6:0] op);
    case (op)
      O_R, O_I, O_LUI, O_AUIPC: return K_ALU;
      O_LD:   return K_LD;
      O_ST:   return K_ST;
      O_BR:   return K_BR;
      O_JAL:  return K_JAL;
      O_JALR: return K_JALR;
      O_SYS:  return K_ECALL;
      default: return K_ILL;
    endcase
  endfunction

  // Runs one instruction starting at its first IF cycle. The memory responder
  // answers after ifd/memd wait cycles; the expected cycle count and strobe
  // tallies come from the instruction class alone.
  task automatic run_instr(input string nm, input logic [6:0] op, input bit bc,
                           input bit hr, input int ifd, input int memd);
    int k, ncyc, e_end, e_ir, e_rw, e_wb, e_pcw, e_pcs, e_mr, e_mw, e_d, e_ret;
    int t_ir, t_rw, t_wb, t_pcw, t_pcs, t_mr, t_mw, t_d, cnt;
    logic [1:0] key, prev_key;
    k = kind(op);
    e_ir = 1; e_rw = 0; e_wb = 0; e_pcw = 0; e_pcs = 0; e_mw = 0; e_d = 0;
    e_end = 0; e_ret = 0;
    t_ir = 0; t_rw = 0; t_wb = 0; t_pcw = 0; t_pcs = 0; t_mr = 0; t_mw = 0; t_d = 0;
    cnt = 0; prev_key = 2'b10;
    e_mr = ifd + 1;
    if (ifd > TO) begin
      ncyc = TO + 1; e_mr = ncyc; e_ir = 0; e_end = 2;
    end else begin
      ncyc = ifd + 2;
      case (k)
        K_ILL: e_end = 2;
        K_ECALL: if (hr) e_end = 1; else begin e_pcw = 1; e_ret = 1; end
        K_BR:   begin ncyc += 1; e_pcw = 1; e_pcs = bc ? 1 : 0; e_ret = 1; end
        K_JAL:  begin ncyc += 1; e_rw = 1; e_wb = 2; e_pcw = 1; e_pcs = 1; e_ret = 1; end
        K_JALR: begin ncyc += 1; e_rw = 1; e_wb = 2; e_pcw = 1; e_pcs = 2; e_ret = 1; end
        K_LD, K_ST: begin
          if (memd > TO) begin
            ncyc += 1 + TO + 1; e_d = TO + 1; e_end = 2;
          end else begin
            ncyc += 1 + memd + 1; e_d = memd + 1; e_ret = 1; e_pcw = 1;
            if (k == K_LD) begin ncyc += 1; e_rw = 1; e_wb = 1; end
          end
          if (k == K_LD) e_mr += e_d; else e_mw = e_d;
        end
        default: begin ncyc += 2; e_rw = 1; e_pcw = 1; e_ret = 1; end
      endcase
    end

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      opcode = op; bcond = bc; halt_req = hr;
      key = {mem_req, i_or_d};
      if (key != prev_key) cnt = 0;
      prev_key = key;
      if (mem_req) mem_ready = (cnt >= (i_or_d ? memd : ifd));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (ir_write) t_ir++;
      if (reg_write) begin t_rw++; t_wb = wb_sel; end
      if (pc_write) begin t_pcw++; t_pcs = pc_source; end
      if (mem_read) t_mr++;
      if (mem_write) t_mw++;
      if (mem_req && i_or_d) t_d++;
      if (mem_req) cnt++;
    end
    @(posedge clk); #1;
    exp_ret += e_ret;
    chk({nm, ".ir_write"}, t_ir, e_ir);
    chk({nm, ".reg_write"}, t_rw, e_rw);
    chk({nm, ".pc_write"}, t_pcw, e_pcw);
    chk({nm, ".mem_read"}, t_mr, e_mr);
    chk({nm, ".mem_write"}, t_mw, e_mw);
    chk({nm, ".data_req"}, t_d, e_d);
    if (e_rw != 0) chk({nm, ".wb_sel"}, t_wb, e_wb);
    if (e_pcw != 0) chk({nm, ".pc_source"}, t_pcs, e_pcs);
    chk({nm, ".retired"}, retired_count, exp_ret);
    case (e_end)
      0: chk({nm, ".next_if"}, {mem_req, i_or_d, is_halted, fault}, 4'b1000);
      1: chk({nm, ".halt"}, {is_halted, fault, mem_req}, 3'b100);
      default: chk({nm, ".fault"}, {fault, is_halted, mem_req}, 3'b100);
    endcase
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", outs, 0);
    chk("reset.retired", retired_count, 0);
    exp_ret = 0;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [10];
    int strobes, held, wr_seen;
    ops[0] = O_R; ops[1] = O_I; ops[2] = O_LD; ops[3] = O_ST; ops[4] = O_BR;
    ops[5] = O_JAL; ops[6] = O_JALR; ops[7] = O_LUI; ops[8] = O_AUIPC; ops[9] = O_SYS;

    do_reset();

    run_instr("add", O_R, 0, 0, 0, 0);
    run_instr("sw", O_ST, 0, 0, 0, 0);
    chk("add_sw.retired2", retired_count, 2);
    run_instr("lw_wait", O_LD, 0, 0, 3, 2);
    run_instr("beq_t", O_BR, 1, 0, 0, 0);
    run_instr("beq_nt", O_BR, 0, 0, 0, 0);
    run_instr("ecall_go", O_SYS, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_instr("rnd", ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 0,
                $urandom_range(0, 4), $urandom_range(0, 4));
    end

    run_instr("if_last_wait", O_I, 0, 0, TO, 0);
    run_instr("sw_last_wait", O_ST, 0, 0, 1, TO);

    run_instr("ecall_halt", O_SYS, 0, 1, 0, 0);
    strobes = 0; held = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      #1;
      strobes += int'(mem_req | mem_read | mem_write | ir_write | reg_write | pc_write);
      held += int'(is_halted & ~fault);
    end
    chk("halt.strobes", strobes, 0);
    chk("halt.held", held, 20);
    do_reset();

    run_instr("if_timeout", O_R, 0, 0, TO + 1, 0);
    do_reset();
    run_instr("lw_timeout", O_LD, 0, 0, 0, TO + 5);
    do_reset();
    run_instr("illegal", 7'b0000000, 0, 0, 0, 0);
    do_reset();

    // Reset asserted while a store waits in MEM.
    run_instr("pre_add", O_R, 0, 0, 0, 0);
    wr_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      opcode = O_ST;
      mem_ready = mem_req & ~i_or_d;
      #1;
    end
    chk("mid_sw.mem_write", mem_write, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_sw.async_outs", outs, 0);
    chk("mid_sw.async_cnt", retired_count, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      wr_seen += int'(mem_write);
    end
    chk("mid_sw.no_write", wr_seen, 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset = 1'b0;
    exp_ret = 0;
    #1;
    chk("mid_sw.release_if", {mem_req, i_or_d, mem_read}, 3'b101);
    run_instr("post_add", O_R, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
